uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer between the `tx_rx` receiver and `APB_UserRegisters` in the UART 16550 design. It captures each character that `tx_rx` delivers, together with that character's parity status, in a 16-entry FIFO. It presents the head entry to the RBR/LSR read path and generates the 16550 receive-trigger and character-timeout interrupt conditions. When `fifo_en` is low it degrades to a single holding register, matching 16450 behaviour.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries, power of two.
- `AW`, 4: log2(`DEPTH`).

Ports:
- `PCLK` in 1: the single clock; all logic is on the rising edge.
- `PRESET` in 1: reset, asynchronous and active-high.
- `rx_data` in 8: received character from `tx_rx`.
- `parity_error` in 1: parity status of `rx_data`.
- `data_ready` in 1: one-cycle push strobe, one per received character.
- `fifo_en` in 1: FCR[0]; 1 = FIFO mode, 0 = single holding register.
- `fifo_clr` in 1: one-cycle pulse, FCR[1] write.
- `rx_trigger` in 2: FCR[7:6]; values 0/1/2/3 set trigger levels 1/4/8/14.
- `baud_rate_cnt` in 16: PCLK cycles per bit period; a value of 0 is treated as 1.
- `rd_pop` in 1: one-cycle pulse on an RBR read.
- `lsr_rd` in 1: one-cycle pulse on an LSR read.
- `rbr_data` out 8: head character.
- `rbr_pe` out 1: parity flag of the head entry (LSR[2]).
- `rx_valid` out 1: FIFO not empty (LSR[0]).
- `overrun` out 1: sticky overrun flag (LSR[1]).
- `fifo_err` out 1: at least one stored entry has PE set (LSR[7]); forced to 0 in non-FIFO mode.
- `count` out AW+1: number of occupied entries, 0..16.
- `trig_irq` out 1: `count` >= trigger level (FIFO mode only).
- `timeout_irq` out 1: character timeout (FIFO mode only).

## Operation
- **Storage:** `DEPTH` x 9-bit circular buffer holding {pe, data}, with write pointer `wp`, read pointer `rp` and counter `count`. Pointers wrap modulo `DEPTH`.
- **Effective depth:** 1 when `fifo_en`=0.
- **Push** (`data_ready`=1):
  - If `count` < effective depth: write the entry at `wp`, increment `wp` and `count`.
  - If full: discard the new character, set `overrun`; stored contents are unchanged.
  - Non-FIFO mode, holding register full: the new character overwrites the holding register and `overrun` is set (16450 semantics).
- **Pop** (`rd_pop`=1 with `count`>0): increment `rp`, decrement `count`. A pop with `count`=0 is ignored.
- **Push and pop in the same cycle:**
  - With `count`>0: both take effect and `count` is unchanged. When full, the push is accepted and `overrun` is not set.
  - With `count`=0: the push takes effect and the pop is ignored.
- **Clear:**
  - `fifo_clr`=1, or any change of `fifo_en`, resets `wp`, `rp` and `count` to 0.
  - Clear has priority over a push or pop in the same cycle; that push is discarded.
  - Clear does not change `overrun`.
- **`overrun` clear:** cleared by `lsr_rd`. If `lsr_rd` and a new overrun occur in the same cycle, `overrun` stays 1.
- **`fifo_err`:** a PE-entry counter increments on a push with PE=1 and decrements on a pop of a head entry with PE=1. `fifo_err` = (counter != 0).
- **Trigger levels:** `trig_irq` = `fifo_en` & (`count` >= {1,4,8,14}[`rx_trigger`]).
- **Timeout:**
  - A prescaler counts PCLK cycles up to `baud_rate_cnt` and emits one tick per bit period.
  - A 6-bit bit counter advances on each tick.
  - Both counters are reset by a push, a pop, a clear, or `count`=0.
  - When the bit counter reaches 40 (four 10-bit character times) with `fifo_en`=1 and `count`>0, `timeout_irq` is set. It holds until the next push, pop or clear.

## Timing
- **Reset values:** all outputs are 0. `wp`, `rp`, `count`, both timeout counters and the PE counter are 0.
- **Push latency:** `data_ready` in cycle N makes `rx_valid`, `count`, `rbr_data`, `rbr_pe` and `trig_irq` update at the edge ending cycle N. They are visible in N+1.
- **Read data:** `rbr_data` and `rbr_pe` are combinational reads of `mem[rp]`. They reflect the next entry in the cycle after `rd_pop`.
- **Overrun:** `overrun` sets at the edge that sees the overflowing push and clears at the edge that sees `lsr_rd`.
- **Timeout latency:** `timeout_irq` asserts exactly 40 x max(`baud_rate_cnt`,1) cycles after the last push/pop edge, provided there is no intervening activity.
- **Asynchronous reset:** asserting `PRESET` mid-operation clears all state immediately, independent of `PCLK`.

## Test plan
- **Basic FIFO order:** `fifo_en`=1, push 0x41, 0x42, 0x43, then pop three times → `rbr_data` reads 0x41, 0x42, 0x43 in order; `count` goes 3→0; `rx_valid` drops after the third pop.
- **Overflow:** push 17 characters 0x00..0x10 with no pops → `count`=16, `overrun`=1, head = 0x00, 0x10 is lost. Then `lsr_rd` → `overrun`=0. Then push and pop in the same cycle while full → `overrun` stays 0 and `count`=16.
- **Trigger levels:** `rx_trigger`=2 → `trig_irq` rises on the cycle after the 8th push and falls after one pop. `rx_trigger`=3 → `trig_irq` first asserts at `count`=14.
- **Timeout:** `baud_rate_cnt`=4, push one character → `timeout_irq`=1 exactly 160 cycles after the push edge; pop → `timeout_irq`=0 next cycle; `count`=0 → never asserts.
- **Parity and non-FIFO mode:**
  - Push 0x55 with PE=1, then 0x66 with PE=0 → `fifo_err`=1 and `rbr_pe`=1; after one pop `rbr_pe`=0 and `fifo_err`=0.
  - `fifo_en`=0, push 0x11 then 0x22 → `rbr_data`=0x22, `overrun`=1, `count`=1.
- **Clear priority and reset:**
  - `fifo_clr` in the same cycle as a push → `count`=0.
  - Assert `PRESET` asynchronously mid-stream → all outputs 0 before the next `PCLK` edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 16550 receive buffer: 16-entry {pe,data} FIFO (single holding register when fifo_en=0).
// Push is visible one cycle later, the head is read combinationally, and an overflowing push sets the sticky overrun flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic [7:0]    rx_data,
  input  logic          parity_error,
  input  logic          data_ready,
  input  logic          fifo_en,
  input  logic          fifo_clr,
  input  logic [1:0]    rx_trigger,
  input  logic [15:0]   baud_rate_cnt,
  input  logic          rd_pop,
  input  logic          lsr_rd,
  output logic [7:0]    rbr_data,
  output logic          rbr_pe,
  output logic          rx_valid,
  output logic          overrun,
  output logic          fifo_err,
  output logic [AW:0]   count,
  output logic          trig_irq,
  output logic          timeout_irq
);

  localparam logic [5:0] BIT_LIMIT = 6'd40;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   pe_cnt;
  logic          en_q;
  logic [15:0]   presc;
  logic [5:0]    bit_cnt;

  logic          clr;
  logic          full;
  logic          do_pop;
  logic          push_acc;
  logic          ovf;
  logic          ovw;
  logic          activity;
  logic          pe_inc;
  logic          pe_dec;
  logic [8:0]    head;
  logic [AW:0]   eff_depth;
  logic [AW:0]   trig_lvl;
  logic [15:0]   presc_max;

  // Toggling fifo_en flushes the buffer just like an FCR[1] write.
  assign clr       = fifo_clr | (fifo_en ^ en_q);
  assign eff_depth = fifo_en ? (AW+1)'(DEPTH) : (AW+1)'(1);
  assign full      = (count >= eff_depth);
  assign do_pop    = rd_pop & (count != '0);
  assign head      = mem[rp];
  assign push_acc  = data_ready & ~clr & (~full | do_pop);
  assign ovf       = data_ready & ~clr & full & ~do_pop;
  assign ovw       = ovf & ~fifo_en;
  assign activity  = data_ready | do_pop | clr;
  assign pe_inc    = (push_acc | ovw) & parity_error;
  assign pe_dec    = (do_pop | ovw) & head[8];
  assign presc_max = (baud_rate_cnt == 16'd0) ? 16'd0 : baud_rate_cnt - 16'd1;

  always_comb begin
    trig_lvl = (AW+1)'(1);
    case (rx_trigger)
      2'd0: trig_lvl = (AW+1)'(1);
      2'd1: trig_lvl = (AW+1)'(4);
      2'd2: trig_lvl = (AW+1)'(8);
      2'd3: trig_lvl = (AW+1)'(14);
      default: trig_lvl = (AW+1)'(1);
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_acc) begin
      mem[wp] <= {parity_error, rx_data};
    end else if (ovw) begin
      // 16450 semantics: the holding register takes the newest character.
      mem[rp] <= {parity_error, rx_data};
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      pe_cnt <= '0;
      en_q   <= 1'b0;
    end else begin
      en_q <= fifo_en;
      if (clr) begin
        wp     <= '0;
        rp     <= '0;
        count  <= '0;
        pe_cnt <= '0;
      end else begin
        if (push_acc) wp <= wp + 1'b1;
        if (do_pop)   rp <= rp + 1'b1;
        case ({push_acc, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        pe_cnt <= pe_cnt + (AW+1)'(pe_inc) - (AW+1)'(pe_dec);
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      overrun <= 1'b0;
    end else if (ovf) begin
      overrun <= 1'b1;
    end else if (lsr_rd) begin
      overrun <= 1'b0;
    end
  end

  // Bit counter saturates at the limit; the interrupt latches until the next activity.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      presc       <= '0;
      bit_cnt     <= '0;
      timeout_irq <= 1'b0;
    end else if (activity) begin
      presc       <= '0;
      bit_cnt     <= '0;
      timeout_irq <= 1'b0;
    end else if (count == '0) begin
      presc   <= '0;
      bit_cnt <= '0;
    end else if (bit_cnt != BIT_LIMIT) begin
      if (presc == presc_max) begin
        presc   <= '0;
        bit_cnt <= bit_cnt + 6'd1;
        if ((bit_cnt == BIT_LIMIT - 6'd1) && fifo_en) timeout_irq <= 1'b1;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

  assign rbr_data = head[7:0];
  assign rbr_pe   = head[8];
  assign rx_valid = (count != '0);
  assign fifo_err = fifo_en & (pe_cnt != '0);
  assign trig_irq = fifo_en & (count >= trig_lvl);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [7:0]  rx_data;
  logic        parity_error;
  logic        data_ready;
  logic        fifo_en;
  logic        fifo_clr;
  logic [1:0]  rx_trigger;
  logic [15:0] baud_rate_cnt;
  logic        rd_pop;
  logic        lsr_rd;
  logic [7:0]  rbr_data;
  logic        rbr_pe;
  logic        rx_valid;
  logic        overrun;
  logic        fifo_err;
  logic [4:0]  count;
  logic        trig_irq;
  logic        timeout_irq;

  always #5 PCLK = ~PCLK;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .rx_data(rx_data), .parity_error(parity_error),
    .data_ready(data_ready), .fifo_en(fifo_en), .fifo_clr(fifo_clr), .rx_trigger(rx_trigger),
    .baud_rate_cnt(baud_rate_cnt), .rd_pop(rd_pop), .lsr_rd(lsr_rd), .rbr_data(rbr_data),
    .rbr_pe(rbr_pe), .rx_valid(rx_valid), .overrun(overrun), .fifo_err(fifo_err),
    .count(count), .trig_irq(trig_irq), .timeout_irq(timeout_irq)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] q[$];
  bit         m_ovr;
  bit         m_prev_en;
  int         m_idle;
  bit         m_tmo;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int trig_level(input logic [1:0] t);
    case (t)
      2'd0: return 1;
      2'd1: return 4;
      2'd2: return 8;
      default: return 14;
    endcase
  endfunction

  function automatic bit any_pe();
    foreach (q[i]) if (q[i][8]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovr = 0; m_prev_en = 0; m_idle = 0; m_tmo = 0;
  endtask

  task automatic model_apply(input bit dr, input logic [7:0] d, input bit pe,
                             input bit pop, input bit lsr, input bit clr);
    bit c, popok, full, ovf, act;
    int eff, sz, b;
    sz = q.size();
    c = clr || (fifo_en != m_prev_en);
    m_prev_en = fifo_en;
    eff = fifo_en ? 16 : 1;
    popok = pop && (sz > 0);
    full = (sz >= eff);
    ovf = 0;
    if (c) q.delete();
    else begin
      if (popok) q.delete(0);
      if (dr) begin
        if (!full || popok) q.push_back({pe, d});
        else begin
          ovf = 1;
          if (!fifo_en) q[0] = {pe, d};
        end
      end
    end
    if (ovf) m_ovr = 1;
    else if (lsr) m_ovr = 0;
    act = dr || popok || c;
    b = (baud_rate_cnt == 16'd0) ? 1 : int'(baud_rate_cnt);
    if (act) begin m_idle = 0; m_tmo = 0; end
    else if (sz == 0) m_idle = 0;
    else begin
      m_idle++;
      if (m_idle == 40 * b && fifo_en) m_tmo = 1;
    end
  endtask

  task automatic compare_all();
    check("count", int'(count), q.size());
    check("rx_valid", int'(rx_valid), int'(q.size() > 0));
    if (q.size() > 0) begin
      check("rbr_data", int'(rbr_data), int'(q[0][7:0]));
      check("rbr_pe", int'(rbr_pe), int'(q[0][8]));
    end
    check("overrun", int'(overrun), int'(m_ovr));
    check("fifo_err", int'(fifo_err), int'(fifo_en && any_pe()));
    check("trig_irq", int'(trig_irq), int'(fifo_en && (q.size() >= trig_level(rx_trigger))));
    check("timeout_irq", int'(timeout_irq), int'(m_tmo));
  endtask

  task automatic cyc(input bit dr, input logic [7:0] d, input bit pe,
                     input bit pop, input bit lsr, input bit clr);
    data_ready = dr; rx_data = d; parity_error = pe;
    rd_pop = pop; lsr_rd = lsr; fifo_clr = clr;
    model_apply(dr, d, pe, pop, lsr, clr);
    @(negedge PCLK);
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_rx_valid"}, int'(rx_valid), 0);
    check({tag, "_rbr_data"}, int'(rbr_data), 0);
    check({tag, "_rbr_pe"}, int'(rbr_pe), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_fifo_err"}, int'(fifo_err), 0);
    check({tag, "_trig_irq"}, int'(trig_irq), 0);
    check({tag, "_timeout_irq"}, int'(timeout_irq), 0);
  endtask

  task automatic measure_timeout(input string tag, input int expect_cycles);
    int lat;
    lat = 0;
    cyc(1, 8'h5A, 0, 0, 0, 0);
    for (int n = 1; n <= 400; n++) begin
      idle();
      if (timeout_irq) begin lat = n; break; end
    end
    check(tag, lat, expect_cycles);
  endtask

  initial begin
    PRESET = 1; fifo_en = 0; fifo_clr = 0; rx_trigger = 0; baud_rate_cnt = 16'd4;
    data_ready = 0; rx_data = 0; parity_error = 0; rd_pop = 0; lsr_rd = 0;
    model_reset();
    repeat (2) @(negedge PCLK);
    check_all_zero("reset");
    PRESET = 0;
    fifo_en = 1;
    idle();

    // Basic order
    cyc(1, 8'h41, 0, 0, 0, 0);
    cyc(1, 8'h42, 0, 0, 0, 0);
    cyc(1, 8'h43, 0, 0, 0, 0);
    check("order_count3", int'(count), 3);
    check("order_head0", int'(rbr_data), 8'h41);
    cyc(0, 0, 0, 1, 0, 0);
    check("order_head1", int'(rbr_data), 8'h42);
    cyc(0, 0, 0, 1, 0, 0);
    check("order_head2", int'(rbr_data), 8'h43);
    cyc(0, 0, 0, 1, 0, 0);
    check("order_count0", int'(count), 0);
    check("order_valid0", int'(rx_valid), 0);

    // Overflow
    for (int i = 0; i <= 16; i++) cyc(1, 8'(i), 0, 0, 0, 0);
    check("ovf_count", int'(count), 16);
    check("ovf_flag", int'(overrun), 1);
    check("ovf_head", int'(rbr_data), 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("ovf_lsr_clr", int'(overrun), 0);
    cyc(1, 8'h77, 0, 1, 0, 0);
    check("full_pushpop_ovr", int'(overrun), 0);
    check("full_pushpop_cnt", int'(count), 16);
    check("full_pushpop_head", int'(rbr_data), 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Trigger levels
    rx_trigger = 2'd2;
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0, 0);
    check("trig8_below", int'(trig_irq), 0);
    cyc(1, 8'h87, 0, 0, 0, 0);
    check("trig8_at", int'(trig_irq), 1);
    cyc(0, 0, 0, 1, 0, 0);
    check("trig8_pop", int'(trig_irq), 0);
    rx_trigger = 2'd3;
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) cyc(1, 8'(i), 0, 0, 0, 0);
    check("trig14_below", int'(trig_irq), 0);
    cyc(1, 8'h0D, 0, 0, 0, 0);
    check("trig14_at", int'(trig_irq), 1);
    rx_trigger = 2'd0;
    cyc(0, 0, 0, 0, 0, 1);

    // Timeout
    baud_rate_cnt = 16'd4;
    measure_timeout("tmo_lat_b4", 160);
    cyc(0, 0, 0, 1, 0, 0);
    check("tmo_pop_clr", int'(timeout_irq), 0);
    repeat (200) idle();
    check("tmo_empty", int'(timeout_irq), 0);
    baud_rate_cnt = 16'd0;
    cyc(0, 0, 0, 0, 0, 1);
    measure_timeout("tmo_lat_b0", 40);
    baud_rate_cnt = 16'd4;
    cyc(0, 0, 0, 0, 0, 1);

    // Parity
    cyc(1, 8'h55, 1, 0, 0, 0);
    cyc(1, 8'h66, 0, 0, 0, 0);
    check("pe_err", int'(fifo_err), 1);
    check("pe_head", int'(rbr_pe), 1);
    cyc(0, 0, 0, 1, 0, 0);
    check("pe_head_after", int'(rbr_pe), 0);
    check("pe_err_after", int'(fifo_err), 0);
    check("pe_data_after", int'(rbr_data), 8'h66);

    // Non-FIFO mode
    fifo_en = 0;
    idle();
    cyc(1, 8'h11, 0, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0, 0);
    check("nf_data", int'(rbr_data), 8'h22);
    check("nf_ovr", int'(overrun), 1);
    check("nf_count", int'(count), 1);
    cyc(0, 0, 0, 0, 1, 0);
    fifo_en = 1;
    idle();

    // Clear priority
    cyc(1, 8'h33, 0, 0, 0, 0);
    cyc(1, 8'h34, 0, 0, 0, 1);
    check("clr_prio", int'(count), 0);

    // Random phases
    for (int ph = 0; ph < 8; ph++) begin
      int pp, pq;
      baud_rate_cnt = 16'($urandom_range(0, 3));
      rx_trigger = 2'($urandom_range(0, 3));
      if (ph == 3) fifo_en = 0;
      if (ph == 5) fifo_en = 1;
      cyc(0, 0, 0, 0, 0, 1);
      case (ph % 4)
        0: begin pp = 500; pq = 300; end
        1: begin pp = 300; pq = 500; end
        2: begin pp = 20;  pq = 10;  end
        default: begin pp = 8; pq = 4; end
      endcase
      for (int k = 0; k < 1500; k++) begin
        bit dr, pop, lsr, clr;
        dr  = ($urandom_range(0, 999) < pp);
        pop = ($urandom_range(0, 999) < pq);
        lsr = ($urandom_range(0, 99) < 5);
        clr = ($urandom_range(0, 999) < 3);
        if ($urandom_range(0, 999) < 2) fifo_en = ~fifo_en;
        cyc(dr, 8'($urandom), bit'($urandom_range(0, 1)), pop, lsr, clr);
      end
      if (ph == 4) begin
        data_ready = 0; rd_pop = 0; lsr_rd = 0; fifo_clr = 0;
        #2 PRESET = 1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge PCLK);
        PRESET = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
